// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU control unit
// and seq_alu, plus the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: and/or/add/sub/slt/nor with flags.
// Ports: ctrl, a, b in; result, overflow, illegal out (sll handled by caller).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow when the result sign disagrees with a under the
    // operand-sign condition for each operation.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            // Signed less-than stays correct across sub overflow.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            ALU_NOR: result = ~(a | b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake in and out, bit-serial sll,
// registered result and flags. Ports: clk, rst_n, in_valid/in_ready,
// alu_control, a, b, shamt, out_valid/out_ready, result, zero,
// overflow, illegal.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    // Keeps in_ready low until the first clock edge after reset release.
    logic             armed_q, armed_d;

    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic             core_ill;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl     (alu_control),
        .a        (a),
        .b        (b),
        .result   (core_res),
        .overflow (core_ovf),
        .illegal  (core_ill)
    );

    assign in_ready  = armed_q && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    always_comb begin
        armed_d  = 1'b1;
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (alu_control == ALU_SLL) begin
                        ovf_d = 1'b0;
                        ill_d = 1'b0;
                        if (shamt == 5'd0) begin
                            result_d = b;
                            zero_d   = (b == '0);
                            state_d  = S_DONE;
                        end else begin
                            sreg_d  = b;
                            cnt_d   = shamt;
                            state_d = S_SHIFT;
                        end
                    end else begin
                        result_d = core_res;
                        zero_d   = (core_res == '0);
                        ovf_d    = core_ovf;
                        ill_d    = core_ill;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_d == 5'd0) begin
                    result_d = sreg_d;
                    zero_d   = (sreg_d == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sreg_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake
// corner sequences, and random ops against a behavioural model.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] c,
                                  input logic [31:0] ma, mb,
                                  input logic [4:0] sh,
                                  output logic [31:0] r,
                                  output logic ov, output logic il);
        longint sa = longint'($signed(ma));
        longint sb = longint'($signed(mb));
        longint s;
        r = 32'd0;
        ov = 1'b0;
        il = 1'b0;
        case (c)
            ALU_AND: r = ma & mb;
            ALU_OR:  r = ma | mb;
            ALU_ADD: begin
                s = sa + sb;
                r = ma + mb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = sa - sb;
                r = ma - mb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_NOR: r = ~(ma | mb);
            ALU_SLL: r = mb << sh;
            default: il = 1'b1;
        endcase
    endfunction

    // One complete transaction. stall = cycles out_ready stays low
    // after out_valid rises; inputs are scrambled after accept.
    task automatic run_op(input logic [3:0] c, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [4:0] sh,
                          input logic [31:0] er, input logic eo,
                          input logic ei, input int stall,
                          input string tag);
        int lat;
        int exp_lat;
        logic [31:0] held;
        exp_lat = (c == ALU_SLL && sh != 5'd0) ? int'(sh) + 1 : 1;
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_control = c;
        a = ia;
        b = ib;
        shamt = sh;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_control = 4'($urandom);
        a = $urandom;
        b = $urandom;
        shamt = 5'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, er);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
        held = result;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_result"}, result, held);
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_valid_fall"}, {31'd0, out_valid}, 32'd0);
        if (stall > 0)
            chk({tag, "_no_bypass"}, result, held);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        ov;
        logic        il;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb, er;
        logic [4:0]  rs;
        logic        eo, ei;
        int          hits;
        logic [3:0]  codes[9];

        vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SLL, 32'h0, 32'h3, 5'd4, 32'h30, 1'b0, 1'b0};
        vecs[4]  = '{ALU_SLL, 32'h0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[5]  = '{4'b0101, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[6]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0};
        vecs[7]  = '{ALU_OR, 32'hF0F0F0F0, 32'h0F000001, 5'd0, 32'hFFF0F0F1, 1'b0, 1'b0};
        vecs[8]  = '{ALU_SUB, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[9]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'h1, 1'b0, 1'b0};
        vecs[12] = '{ALU_SLL, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{4'b0011, 32'hFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b1};

        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
                  ALU_NOR, ALU_SLL, 4'b1010, 4'b0100};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        alu_control = 4'd0;
        a = 32'd0;
        b = 32'd0;
        shamt = 5'd0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post_edge", {31'd0, in_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].sh,
                   vecs[i].r, vecs[i].ov, vecs[i].il, 0,
                   $sformatf("vec%0d", i));

        // nor held under back-pressure for 3 cycles
        run_op(ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 3,
               "nor_hold");
        // sll held under back-pressure
        run_op(ALU_SLL, 32'h0, 32'h5, 5'd3, 32'h28, 1'b0, 1'b0, 2,
               "sll_hold");

        // Reset pulse during SHIFT aborts the operation
        @(negedge clk);
        in_valid = 1'b1;
        alu_control = ALU_SLL;
        b = 32'h1;
        shamt = 5'd20;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_mid_shift_valid", {31'd0, out_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) hits++;
        end
        chk("abort_no_result", hits, 0);
        chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Random ops against the behavioural model
        for (int i = 0; i < 150; i++) begin
            rc = codes[$urandom_range(0, 8)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 12));
            model(rc, ra, rb, rs, er, eo, ei);
            run_op(rc, ra, rb, rs, er, eo, ei, $urandom_range(0, 2),
                   $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
